// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//   Forwarding, stall and flush control for a 5-stage RISC-V pipeline.
//   Covers load-use hazards, taken branches and multi-cycle Execute ops.
//   A small IDLE/BUSY FSM with an 8-bit down-counter holds the front of the
//   pipeline while a multi-cycle op occupies Execute.
//
// Parameters
//   AW     register-address width
//   MC_LAT Execute occupancy of a multi-cycle op, 1..255 cycles
//   CNT_W  performance counter width
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   Rs1_D, Rs2_D             Decode sources
//   Rs1_E, Rs2_E, RD_E       Execute sources / destination
//   ResultSrcE               Execute instruction is a load
//   MultiCycleE              Execute instruction is a multi-cycle op
//   PCSrcE                   branch/jump taken in Execute
//   RegWriteM, RD_M          Memory-stage writeback
//   RegWriteW, RD_W          Writeback-stage writeback
//   ForwardAE, ForwardBE     00 regfile, 01 ResultW, 10 ALU_ResultM
//   StallF, StallD, StallE   hold PC / Decode reg / Execute reg
//   FlushD, FlushE, FlushM   bubble into Decode / Execute / Memory reg
//   DoneE                    multi-cycle result valid this cycle
//   StallCnt, FlushCnt       saturating performance counters
//
// Build option
//   HAZARD_PERF_EN  when defined, StallCnt/FlushCnt are real saturating
//                   counters; otherwise they are tied to zero.
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
  parameter int AW     = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    Rs1_D,
  input  logic [AW-1:0]    Rs2_D,
  input  logic [AW-1:0]    Rs1_E,
  input  logic [AW-1:0]    Rs2_E,
  input  logic [AW-1:0]    RD_E,
  input  logic             ResultSrcE,
  input  logic             MultiCycleE,
  input  logic             PCSrcE,
  input  logic             RegWriteM,
  input  logic [AW-1:0]    RD_M,
  input  logic             RegWriteW,
  input  logic [AW-1:0]    RD_W,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             DoneE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // The start cycle is itself a stall cycle, so BUSY needs MC_LAT-2 more.
  localparam logic [7:0] MC_LOAD   = (MC_LAT > 1) ? 8'(MC_LAT - 2) : 8'd0;
  localparam bit         MC_SINGLE = (MC_LAT == 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       mc_req, mc_start, mc_hold, mc_stall, mc_done;
  logic       lu, br_flush;
  logic [1:0] fwd_a, fwd_b;

  // A taken branch alongside MultiCycleE wins: the op never starts.
  assign mc_req   = MultiCycleE & ~PCSrcE;
  assign mc_start = (state_q == IDLE) & mc_req & ~MC_SINGLE;
  assign mc_hold  = (state_q == BUSY) & (cnt_q != 8'd0);
  assign mc_stall = mc_start | mc_hold;
  assign mc_done  = ((state_q == BUSY) & (cnt_q == 8'd0)) |
                    ((state_q == IDLE) & mc_req & MC_SINGLE);

  assign lu = ResultSrcE & (RD_E != '0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));

  // Branch flush only when no multi-cycle stall is holding the pipe.
  assign br_flush = PCSrcE & ~mc_stall;

  // Memory stage is younger data, so it wins over Writeback.
  assign fwd_a = (RegWriteM & (RD_M != '0) & (RD_M == Rs1_E)) ? 2'b10 :
                 (RegWriteW & (RD_W != '0) & (RD_W == Rs1_E)) ? 2'b01 : 2'b00;
  assign fwd_b = (RegWriteM & (RD_M != '0) & (RD_M == Rs2_E)) ? 2'b10 :
                 (RegWriteW & (RD_W != '0) & (RD_W == Rs2_E)) ? 2'b01 : 2'b00;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state (MultiCycleE is ignored in BUSY, the op is being held)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mc_start) begin
          state_d = BUSY;
          cnt_d   = MC_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM / hazard outputs: multi-cycle stall > branch > load-use.
  // Everything is forced low while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    DoneE     = 1'b0;
    if (rst) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      DoneE     = mc_done;
      if (mc_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (br_flush) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lu) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (br_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic ResultSrcE, MultiCycleE, PCSrcE, RegWriteM, RegWriteW;

  logic [1:0] ForwardAE, ForwardBE, ForwardAE1, ForwardBE1;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, DoneE;
  logic StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, DoneE1;
  logic [CW-1:0] StallCnt, FlushCnt, StallCnt1, FlushCnt1;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.AW(AW), .MC_LAT(LAT), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E),
    .ResultSrcE(ResultSrcE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RD_M(RD_M), .RegWriteW(RegWriteW), .RD_W(RD_W),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .DoneE(DoneE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt));

  // Single-cycle variant shares the stimulus.
  hazard_ctrl_unit #(.AW(AW), .MC_LAT(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E),
    .ResultSrcE(ResultSrcE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RD_M(RD_M), .RegWriteW(RegWriteW), .RD_W(RD_W),
    .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1),
    .StallF(StallF1), .StallD(StallD1), .StallE(StallE1),
    .FlushD(FlushD1), .FlushE(FlushE1), .FlushM(FlushM1), .DoneE(DoneE1),
    .StallCnt(StallCnt1), .FlushCnt(FlushCnt1));

  // {FAE[10:9], FBE[8:7], SF6, SD5, SE4, FD3, FE2, FM1, DoneE0}
  wire [10:0] ctrl  = {ForwardAE, ForwardBE, StallF, StallD, StallE,
                       FlushD, FlushE, FlushM, DoneE};
  wire [10:0] ctrl1 = {ForwardAE1, ForwardBE1, StallF1, StallD1, StallE1,
                       FlushD1, FlushE1, FlushM1, DoneE1};

  int nchk = 0;
  int npass = 0;

  // Reference model state: age = cycles the current multi-cycle op has
  // already spent in Execute (0 = none in progress).
  int age = 0;
  int scnt = 0;
  int fcnt = 0;

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] exp_ctrl(input int lat, input int a);
    logic [10:0] e;
    bit op, mstall, done, lu;
    e = '0;
    if (!rst) return e;
    e[10:9] = fwd(Rs1_E);
    e[8:7]  = fwd(Rs2_E);
    op     = (a > 0) || (MultiCycleE && !PCSrcE);
    mstall = op && (a < lat - 1);
    done   = op && (a == lat - 1);
    lu     = ResultSrcE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
    e[0] = done;
    if (mstall)      begin e[6] = 1; e[5] = 1; e[4] = 1; e[1] = 1; end
    else if (PCSrcE) begin e[3] = 1; e[2] = 1; end
    else if (lu)     begin e[6] = 1; e[5] = 1; e[2] = 1; end
    return e;
  endfunction

  function automatic logic [CW-1:0] exp_scnt();
`ifdef HAZARD_PERF_EN
    return CW'(scnt);
`else
    return '0;
`endif
  endfunction

  function automatic logic [CW-1:0] exp_fcnt();
`ifdef HAZARD_PERF_EN
    return CW'(fcnt);
`else
    return '0;
`endif
  endfunction

  // Advance one clock and the model with it.
  task automatic tick();
    logic [10:0] e;
    bit op;
    e  = exp_ctrl(LAT, age);
    op = (age > 0) || (MultiCycleE && !PCSrcE);
    @(posedge clk);
    if (!rst) begin
      age = 0; scnt = 0; fcnt = 0;
    end else begin
      if (e[6]) scnt = (scnt < CMAX) ? scnt + 1 : CMAX;
      if (e[3]) fcnt = (fcnt < CMAX) ? fcnt + 1 : CMAX;
      age = (op && age != LAT - 1) ? age + 1 : 0;
    end
    #1;
  endtask

  task automatic drive_idle();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    ResultSrcE = 0; MultiCycleE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    rst = 0;
    Rs1_E = 5; RegWriteM = 1; RD_M = 5; MultiCycleE = 1; PCSrcE = 0;
    ResultSrcE = 1; RD_E = 3; Rs1_D = 3;
    tick(); tick();
    #2;
    e = exp_ctrl(LAT, age);
    nchk++;
    if (ctrl !== e) $display("FAIL reset_ctrl got %b exp %b", ctrl, e); else npass++;
    nchk++;
    if (StallCnt !== 0 || FlushCnt !== 0)
      $display("FAIL reset_cnt got %0d/%0d exp 0/0", StallCnt, FlushCnt);
    else npass++;
    drive_idle();
    rst = 1;
    tick();
  endtask

  task automatic test_forward();
    logic [10:0] e;
    for (int s = 0; s < 4; s++) begin
      drive_idle();
      Rs1_E = 5; Rs2_E = 9;
      case (s)
        0: begin RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; end
        1: begin RegWriteM = 0; RD_M = 5; RegWriteW = 1; RD_W = 5; end
        2: begin RegWriteM = 1; RD_M = 0; RegWriteW = 1; RD_W = 0; Rs1_E = 0; end
        default: begin RegWriteM = 1; RD_M = 9; RegWriteW = 1; RD_W = 5; end
      endcase
      #2;
      e = exp_ctrl(LAT, age);
      nchk++;
      if (ctrl !== e) $display("FAIL forward_%0d got %b exp %b", s, ctrl, e); else npass++;
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [10:0] e;
    for (int s = 0; s < 3; s++) begin
      drive_idle();
      ResultSrcE = (s != 2);
      RD_E = (s == 1) ? 5'd0 : 5'd7;
      Rs2_D = (s == 1) ? 5'd0 : 5'd7;
      #2;
      e = exp_ctrl(LAT, age);
      nchk++;
      if (ctrl !== e) $display("FAIL load_use_%0d got %b exp %b", s, ctrl, e); else npass++;
      tick();
    end
  endtask

  task automatic test_branch();
    logic [10:0] e;
    drive_idle();
    ResultSrcE = 1; RD_E = 7; Rs2_D = 7; PCSrcE = 1;
    #2;
    e = exp_ctrl(LAT, age);
    nchk++;
    if (ctrl !== e) $display("FAIL branch got %b exp %b", ctrl, e); else npass++;
    tick();
    // Illegal PCSrcE+MultiCycleE: branch wins, no op starts.
    MultiCycleE = 1;
    #2;
    e = exp_ctrl(LAT, age);
    nchk++;
    if (ctrl !== e) $display("FAIL branch_mc got %b exp %b", ctrl, e); else npass++;
    tick();
    drive_idle();
    #2;
    e = exp_ctrl(LAT, age);
    nchk++;
    if (ctrl !== e) $display("FAIL branch_after got %b exp %b", ctrl, e); else npass++;
    nchk++;
    if (FlushCnt !== exp_fcnt()) $display("FAIL flush_cnt got %0d exp %0d", FlushCnt, exp_fcnt());
    else npass++;
    tick();
  endtask

  task automatic test_multicycle();
    logic [10:0] e;
    drive_idle();
    MultiCycleE = 1;
    for (int c = 0; c < 2 * LAT; c++) begin
      #2;
      e = exp_ctrl(LAT, age);
      nchk++;
      if (ctrl !== e) $display("FAIL mc_c%0d got %b exp %b", c, ctrl, e); else npass++;
      nchk++;
      if (DoneE1 !== 1'b1 || StallF1 !== 1'b0 || ctrl1[6:1] !== 6'b0)
        $display("FAIL mc_lat1_c%0d got done=%b ctl=%b exp done=1 ctl=000000", c, DoneE1, ctrl1[6:1]);
      else npass++;
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_busy();
    logic [10:0] e;
    drive_idle();
    MultiCycleE = 1;
    tick();                       // start cycle
    rst = 0;                      // second stall cycle
    tick();
    #2;
    e = exp_ctrl(LAT, age);
    nchk++;
    if (ctrl !== e || StallCnt !== 0) $display("FAIL rst_busy got %b/%0d exp %b/0", ctrl, StallCnt, e);
    else npass++;
    rst = 1;
    for (int c = 0; c < LAT; c++) begin
      #2;
      e = exp_ctrl(LAT, age);
      nchk++;
      if (ctrl !== e) $display("FAIL rst_busy_re%0d got %b exp %b", c, ctrl, e); else npass++;
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_saturation();
    rst = 0; tick(); rst = 1;
    drive_idle();
    ResultSrcE = 1; RD_E = 7; Rs2_D = 7;
    repeat (20) tick();
    #2;
    nchk++;
    if (StallCnt !== exp_scnt()) $display("FAIL stall_sat got %0d exp %0d", StallCnt, exp_scnt());
    else npass++;
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    logic [10:0] e;
    int bad = 0;
    rst = 0; tick(); rst = 1;
    for (int c = 0; c < 400; c++) begin
      Rs1_D = AW'($urandom_range(0, 3)); Rs2_D = AW'($urandom_range(0, 3));
      Rs1_E = AW'($urandom_range(0, 3)); Rs2_E = AW'($urandom_range(0, 3));
      RD_E  = AW'($urandom_range(0, 3)); RD_M  = AW'($urandom_range(0, 3));
      RD_W  = AW'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      ResultSrcE  = ($urandom_range(0, 2) == 0);
      MultiCycleE = ($urandom_range(0, 5) == 0);
      PCSrcE      = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 59) != 0);
      #2;
      e = exp_ctrl(LAT, age);
      nchk++;
      if (ctrl !== e) begin
        if (bad < 8) $display("FAIL rand_c%0d got %b exp %b", c, ctrl, e);
        bad++;
      end else npass++;
      nchk++;
      if (StallCnt !== exp_scnt() || FlushCnt !== exp_fcnt()) begin
        if (bad < 8) $display("FAIL rand_cnt_c%0d got %0d/%0d exp %0d/%0d",
                              c, StallCnt, FlushCnt, exp_scnt(), exp_fcnt());
        bad++;
      end else npass++;
      tick();
    end
    rst = 1;
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst = 0;
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_multicycle();
    test_reset_busy();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
